// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings
// and the counter saturation helper.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned MAX_CNT_WIDTH = 32;

    // All-ones value of a counter of the given width, i.e. its saturation point.
    function automatic logic [MAX_CNT_WIDTH-1:0] cnt_sat_max(input int unsigned width);
        if (width >= MAX_CNT_WIDTH) begin
            return '1;
        end
        return (MAX_CNT_WIDTH'(1) << width) - MAX_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, edge history, mode-selected hit logic,
// optional pulse register, sticky pending flag and saturating event counter.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int REGISTERED_OUT = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig_i,
    input  logic [1:0]           mode_i,
    input  logic                 primed_i,
    input  logic                 clear_i,
    input  logic                 count_clr_i,
    output logic                 edge_pulse_o,
    output logic                 pending_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_sat_max(CNT_WIDTH));

    logic                 s;
    logic                 last_q;
    logic                 rise;
    logic                 fall;
    logic                 hit;
    logic                 qual;
    logic                 pending_q;
    logic                 pending_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig_i;
        end else begin : g_sync
            logic sync_q [SYNC_STAGES];

            // NOTE: synchroniser flops are reset as well, so s and last start
            // at a known 0 and the priming window fully covers their fill-up.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= 1'b0;
                    end
                end else begin
                    sync_q[0] <= sig_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= s;
        end
    end

    assign rise = s & ~last_q;
    assign fall = ~s & last_q;

    // NOTE: hit gets a default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        hit = 1'b0;
        case (edge_mode_e'(mode_i))
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
    end

    assign qual = hit & primed_i;

    generate
        if (REGISTERED_OUT != 0) begin : g_reg_out
            logic pulse_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= qual;
                end
            end

            assign edge_pulse_o = pulse_q;
        end else begin : g_mealy_out
            assign edge_pulse_o = qual;
        end
    endgenerate

    // A new event outranks a coincident clear so it is never lost.
    always_comb begin
        pending_d = pending_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (qual) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr_i) begin
            cnt_d = qual ? CNT_WIDTH'(1) : '0;
        end else if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o = pending_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel detectors plus shared priming
// counter, irq aggregation and the count readback mux.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int REGISTERED_OUT = 0,
    parameter int CNT_WIDTH      = 8,
    parameter int SEL_W          = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   sig,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    input  logic [SEL_W-1:0]      count_sel,
    input  logic                  count_clr,
    output logic [CHANNELS-1:0]   edge_pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  primed
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

    logic [PRIME_W-1:0]   prime_cnt_q;
    logic [PRIME_W-1:0]   prime_cnt_d;
    logic [CNT_WIDTH-1:0] counts [CHANNELS];

    // Priming holds off events until the synchroniser and history are filled
    // with post-reset samples; it then parks at its terminal count.
    assign primed      = (prime_cnt_q == PRIME_W'(PRIME_CYCLES));
    assign prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_cnt_q <= '0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic ch_count_clr;

            assign ch_count_clr = count_clr && (count_sel == SEL_W'(i));

            edge_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .REGISTERED_OUT(REGISTERED_OUT),
                .CNT_WIDTH     (CNT_WIDTH)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .sig_i        (sig[i]),
                .mode_i       (mode[2*i+1:2*i]),
                .primed_i     (primed),
                .clear_i      (clear[i]),
                .count_clr_i  (ch_count_clr),
                .edge_pulse_o (edge_pulse[i]),
                .pending_o    (pending[i]),
                .count_o      (counts[i])
            );
        end
    endgenerate

    assign irq = |pending;

    // Out-of-range selects read as zero.
    always_comb begin
        count_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (count_sel == SEL_W'(i)) begin
                count_out = counts[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised self-checking bench for multi_edge_detector: three configurations
// driven in lockstep against a model built on the history of sampled inputs.
module tb_multi_edge_detector;

    localparam int ND = 3;

    logic       clk;
    logic       reset;
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] clear;
    logic [1:0] count_sel;
    logic       count_clr;

    logic [3:0] o_pulse  [ND];
    logic [3:0] o_pend   [ND];
    logic       o_irq    [ND];
    logic [7:0] o_cnt    [ND];
    logic       o_primed [ND];

    logic [3:0] cnt0;
    logic [2:0] pulse2;
    logic [2:0] pend2;
    logic [3:0] cnt2;

    int checks;
    int errors;

    // Model state: sampled-input history since reset release plus per-channel state.
    logic [3:0] v [$];
    int         k;
    bit         pend [ND][4];
    bit         regp [ND][4];
    int         cnt  [ND][4];

    // d0: SYNC=2 Mealy 4-bit counters; d1: SYNC=2 registered 8-bit;
    // d2: SYNC=0 Mealy, 3 channels, 4-bit counters.
    multi_edge_detector #(
        .CHANNELS(4), .SYNC_STAGES(2), .REGISTERED_OUT(0), .CNT_WIDTH(4), .SEL_W(2)
    ) dut0 (
        .clk(clk), .reset(reset), .sig(sig), .mode(mode), .clear(clear),
        .count_sel(count_sel), .count_clr(count_clr),
        .edge_pulse(o_pulse[0]), .pending(o_pend[0]), .irq(o_irq[0]),
        .count_out(cnt0), .primed(o_primed[0])
    );

    multi_edge_detector #(
        .CHANNELS(4), .SYNC_STAGES(2), .REGISTERED_OUT(1), .CNT_WIDTH(8), .SEL_W(2)
    ) dut1 (
        .clk(clk), .reset(reset), .sig(sig), .mode(mode), .clear(clear),
        .count_sel(count_sel), .count_clr(count_clr),
        .edge_pulse(o_pulse[1]), .pending(o_pend[1]), .irq(o_irq[1]),
        .count_out(o_cnt[1]), .primed(o_primed[1])
    );

    multi_edge_detector #(
        .CHANNELS(3), .SYNC_STAGES(0), .REGISTERED_OUT(0), .CNT_WIDTH(4), .SEL_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .sig(sig[2:0]), .mode(mode[5:0]), .clear(clear[2:0]),
        .count_sel(count_sel), .count_clr(count_clr),
        .edge_pulse(pulse2), .pending(pend2), .irq(o_irq[2]),
        .count_out(cnt2), .primed(o_primed[2])
    );

    assign o_cnt[0]   = {4'b0, cnt0};
    assign o_pulse[2] = {1'b0, pulse2};
    assign o_pend[2]  = {1'b0, pend2};
    assign o_cnt[2]   = {4'b0, cnt2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stg(input int d);
        return (d == 2) ? 0 : 2;
    endfunction

    function automatic bit reg_of(input int d);
        return (d == 1);
    endfunction

    function automatic int wid(input int d);
        return (d == 1) ? 8 : 4;
    endfunction

    function automatic int nch(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic logic [3:0] getv(input int j);
        if (j < 1 || j >= v.size()) return 4'b0;
        return v[j];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        k = 0;
        v.delete();
        v.push_back(4'b0);
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 4; c++) begin
                pend[d][c] = 1'b0;
                regp[d][c] = 1'b0;
                cnt[d][c]  = 0;
            end
        end
    endtask

    task automatic check_zero(input string where);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_d%0d_pulse", where, d), 32'(o_pulse[d]), 0);
            check($sformatf("%s_d%0d_pending", where, d), 32'(o_pend[d]), 0);
            check($sformatf("%s_d%0d_irq", where, d), 32'(o_irq[d]), 0);
            check($sformatf("%s_d%0d_count", where, d), 32'(o_cnt[d]), 0);
            check($sformatf("%s_d%0d_primed", where, d), 32'(o_primed[d]), 0);
        end
    endtask

    // Called mid-cycle k (after edge k, before edge k+1) with inputs stable.
    // s during cycle k is the input sampled at edge k-S+1; last is one sample older.
    task automatic model_cycle();
        logic [3:0] sv, lv, ep, epend, q;
        logic [7:0] ecnt;
        logic [1:0] m;
        bit         r, f, hit, prim;
        int         s_n;
        if (!reset) begin
            check_zero("in_reset");
            model_clear();
            return;
        end
        v.push_back(sig);
        for (int d = 0; d < ND; d++) begin
            s_n   = stg(d);
            sv    = getv(k - s_n + 1);
            lv    = getv(k - s_n);
            prim  = (k >= s_n + 1);
            ep    = '0;
            epend = '0;
            q     = '0;
            for (int c = 0; c < nch(d); c++) begin
                m   = mode[2*c +: 2];
                r   = sv[c] && !lv[c];
                f   = !sv[c] && lv[c];
                hit = (m == 2'd1 && r) || (m == 2'd2 && f) || (m == 2'd3 && (r || f));
                q[c]     = hit && prim;
                ep[c]    = reg_of(d) ? regp[d][c] : q[c];
                epend[c] = pend[d][c];
            end
            ecnt = (int'(count_sel) < nch(d)) ? 8'(cnt[d][count_sel]) : 8'd0;
            check($sformatf("d%0d_pulse_k%0d", d, k), 32'(o_pulse[d]), 32'(ep));
            check($sformatf("d%0d_pending_k%0d", d, k), 32'(o_pend[d]), 32'(epend));
            check($sformatf("d%0d_irq_k%0d", d, k), 32'(o_irq[d]), 32'(|epend));
            check($sformatf("d%0d_count_k%0d", d, k), 32'(o_cnt[d]), 32'(ecnt));
            check($sformatf("d%0d_primed_k%0d", d, k), 32'(o_primed[d]), 32'(prim));
            for (int c = 0; c < nch(d); c++) begin
                regp[d][c] = q[c];
                pend[d][c] = q[c] || (pend[d][c] && !clear[c]);
                if (count_clr && int'(count_sel) == c) begin
                    cnt[d][c] = q[c] ? 1 : 0;
                end else if (q[c] && cnt[d][c] < (1 << wid(d)) - 1) begin
                    cnt[d][c] = cnt[d][c] + 1;
                end
            end
        end
        k++;
    endtask

    task automatic drive(input logic rst_in, input logic [3:0] s_in, input logic [7:0] m_in,
                         input logic [3:0] c_in, input logic [1:0] sel_in, input logic cc_in);
        @(posedge clk);
        #1;
        reset     = rst_in;
        sig       = s_in;
        mode      = m_in;
        clear     = c_in;
        count_sel = sel_in;
        count_clr = cc_in;
        @(negedge clk);
        model_cycle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rs;
        logic [7:0] rm;
        logic [3:0] rc;
        logic       rst;
        int         hold;

        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        sig       = 4'b0;
        mode      = 8'h00;
        clear     = 4'b0;
        count_sel = 2'd0;
        count_clr = 1'b0;
        model_clear();

        // Reset release with all inputs high and mode both: priming hides the rise.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'hF, 8'hFF, 4'h0, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 4'hF, 8'hFF, 4'h0, 2'd0, 1'b0);

        // Channel 0 rise-only: 0, 1, 0 held four cycles each.
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0000, 8'h01, 4'h0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0001, 8'h01, 4'h0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0000, 8'h01, 4'h0, 2'd0, 1'b0);

        // Channel 1 both-edges, toggled every cycle for ten cycles.
        for (int i = 0; i < 10; i++) drive(1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0000, 8'h0C, 4'h0, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0000, 8'h0C, 4'h0, 2'd1, 1'b0);

        // Channel 2 fall-only with clear coincident with the hit, then a lone clear.
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0100, 8'h20, 4'h0, 2'd2, 1'b0);
        drive(1'b1, 4'b0000, 8'h20, 4'h0, 2'd2, 1'b0);
        drive(1'b1, 4'b0000, 8'h20, 4'h0, 2'd2, 1'b0);
        drive(1'b1, 4'b0000, 8'h20, 4'h4, 2'd2, 1'b0);
        drive(1'b1, 4'b0000, 8'h20, 4'h4, 2'd2, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 4'b0000, 8'h20, 4'h0, 2'd2, 1'b0);
        drive(1'b1, 4'b0000, 8'h20, 4'hF, 2'd2, 1'b0);

        // Channel 3 rise-only: 20 rises to saturate, then clear coincident with a rise.
        for (int i = 0; i < 40; i++) drive(1'b1, (i % 2 == 0) ? 4'b1000 : 4'b0000, 8'h40, 4'h0, 2'd3, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 4'b0000, 8'h40, 4'h0, 2'd3, 1'b0);
        drive(1'b1, 4'b1000, 8'h40, 4'h0, 2'd3, 1'b0);
        drive(1'b1, 4'b1000, 8'h40, 4'h0, 2'd3, 1'b0);
        drive(1'b1, 4'b1000, 8'h40, 4'h0, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'b1000, 8'h40, 4'h0, 2'd3, 1'b0);

        // Asynchronous reset mid-cycle while channel 3 is counting.
        for (int i = 0; i < 6; i++) drive(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1000, 8'hFF, 4'h0, 2'd3, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        model_cycle();
        for (int i = 0; i < 2; i++) drive(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000, 8'hFF, 4'h0, 2'd3, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0) ? 4'b1111 : 4'b0000, 8'hFF, 4'h0, 2'd3, 1'b0);

        // Randomised traffic with occasional mode changes, clears and resets.
        rm   = 8'hFF;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rs = 4'($urandom);
            if ($urandom_range(15) == 0) rm = 8'($urandom);
            rc = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (hold == 0 && $urandom_range(499) == 0) hold = $urandom_range(3, 1);
            rst = (hold == 0);
            if (hold > 0) hold--;
            drive(rst, rs, rm, rc, 2'($urandom), ($urandom_range(15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
